// File: rtl/pwm_profile_sequencer_if.sv
// pwm_profile_sequencer_if
// Groups the signals between the sequencer, the button/rotary front end
// and the PWM generator / LCD status logic.
//   mode_btn    one-cycle pulse, toggles MANUAL/AUTO
//   rot_event   one-cycle pulse per encoder detent
//   rot_right   direction qualifier for rot_event (1 = decrement)
//   period_end  one-cycle pulse on the last tick of each PWM period
//   duty_level  committed duty in 5% units
//   cfg_valid   one-cycle pulse when duty_level takes a new value
//   state_code  0 MANUAL, 1 RAMP_UP, 2 HOLD_HIGH, 3 RAMP_DOWN, 4 HOLD_LOW
//   rate        AUTO step rate, 0 slowest .. 7 fastest
// The master modport is the front-end side; the slave modport is the sequencer.
interface pwm_profile_sequencer_if;
    logic       mode_btn;
    logic       rot_event;
    logic       rot_right;
    logic       period_end;
    logic [4:0] duty_level;
    logic       cfg_valid;
    logic [2:0] state_code;
    logic [2:0] rate;

    modport master (
        output mode_btn, rot_event, rot_right, period_end,
        input  duty_level, cfg_valid, state_code, rate
    );

    modport slave (
        input  mode_btn, rot_event, rot_right, period_end,
        output duty_level, cfg_valid, state_code, rate
    );
endinterface

// File: rtl/pwm_profile_sequencer.sv
// pwm_profile_sequencer
// Drives the duty-cycle setting of the LED PWM generator. In MANUAL mode the
// encoder sets a pending level; in AUTO mode a breathing profile ramps the
// duty up and down. Duty changes are only committed on period_end so the LED
// never glitches inside a PWM period.
// Ports:
//   clk    system clock
//   reset  asynchronous active-low reset
//   bus    slave side of pwm_profile_sequencer_if (see interface header)
module pwm_profile_sequencer #(
    parameter int MAX_LEVEL    = 20,
    parameter int HOLD_PERIODS = 8,
    parameter int RATE_RESET   = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    pwm_profile_sequencer_if.slave   bus
);

    localparam logic [2:0] ST_MANUAL    = 3'd0;
    localparam logic [2:0] ST_RAMP_UP   = 3'd1;
    localparam logic [2:0] ST_HOLD_HIGH = 3'd2;
    localparam logic [2:0] ST_RAMP_DOWN = 3'd3;
    localparam logic [2:0] ST_HOLD_LOW  = 3'd4;

    localparam int         HOLD_W    = $clog2(HOLD_PERIODS + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_PERIODS - 1);
    localparam logic [4:0] MAX_DUTY  = 5'(MAX_LEVEL);
    localparam logic [2:0] RATE_INIT = 3'(RATE_RESET);

    logic [2:0]        state;
    logic [4:0]        duty;
    logic [4:0]        pending;
    logic [2:0]        rate_q;
    logic [2:0]        step_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              cfg_q;

    assign bus.duty_level = duty;
    assign bus.cfg_valid  = cfg_q;
    assign bus.state_code = state;
    assign bus.rate       = rate_q;

    // Single sequencer register block. The mode toggle takes priority over
    // everything else on its edge, so a coincident period_end neither commits
    // nor steps. In MANUAL mode the commit reads pending before the rotation
    // on the same edge updates it. In AUTO mode the step compare uses the
    // rate from before any coincident rotation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_MANUAL;
            duty     <= '0;
            pending  <= '0;
            rate_q   <= RATE_INIT;
            step_cnt <= '0;
            hold_cnt <= '0;
            cfg_q    <= 1'b0;
        end else begin
            cfg_q <= 1'b0;
            if (bus.mode_btn) begin
                if (state == ST_MANUAL) begin
                    state    <= (duty == MAX_DUTY) ? ST_RAMP_DOWN : ST_RAMP_UP;
                    step_cnt <= '0;
                    hold_cnt <= '0;
                end else begin
                    state   <= ST_MANUAL;
                    pending <= duty;
                end
            end else if (state == ST_MANUAL) begin
                if (bus.period_end && (pending != duty)) begin
                    duty  <= pending;
                    cfg_q <= 1'b1;
                end
                if (bus.rot_event) begin
                    if (!bus.rot_right) begin
                        if (pending != MAX_DUTY) pending <= pending + 5'd1;
                    end else begin
                        if (pending != 5'd0) pending <= pending - 5'd1;
                    end
                end
            end else begin
                if (bus.rot_event) begin
                    if (!bus.rot_right) begin
                        if (rate_q != 3'd7) rate_q <= rate_q + 3'd1;
                    end else begin
                        if (rate_q != 3'd0) rate_q <= rate_q - 3'd1;
                    end
                end
                if (bus.period_end) begin
                    case (state)
                        ST_RAMP_UP: begin
                            if (step_cnt == (3'd7 - rate_q)) begin
                                step_cnt <= '0;
                                duty     <= duty + 5'd1;
                                cfg_q    <= 1'b1;
                                if ((duty + 5'd1) == MAX_DUTY) begin
                                    state    <= ST_HOLD_HIGH;
                                    hold_cnt <= '0;
                                end
                            end else begin
                                step_cnt <= step_cnt + 3'd1;
                            end
                        end
                        ST_RAMP_DOWN: begin
                            if (step_cnt == (3'd7 - rate_q)) begin
                                step_cnt <= '0;
                                duty     <= duty - 5'd1;
                                cfg_q    <= 1'b1;
                                if (duty == 5'd1) begin
                                    state    <= ST_HOLD_LOW;
                                    hold_cnt <= '0;
                                end
                            end else begin
                                step_cnt <= step_cnt + 3'd1;
                            end
                        end
                        ST_HOLD_HIGH, ST_HOLD_LOW: begin
                            if (hold_cnt == HOLD_LAST) begin
                                state    <= (state == ST_HOLD_HIGH) ? ST_RAMP_DOWN : ST_RAMP_UP;
                                step_cnt <= '0;
                                hold_cnt <= '0;
                            end else begin
                                hold_cnt <= hold_cnt + 1'b1;
                            end
                        end
                        default: state <= ST_MANUAL;
                    endcase
                end
            end
        end
    end

endmodule

// File: doc/pwm_profile_sequencer.md
Name: pwm_profile_sequencer

Overview:
Controller that drives the duty-cycle setting of the LED PWM generator. It runs in two modes. In MANUAL mode the duty level is set from the rotary encoder. In AUTO mode a breathing profile ramps the duty up and down automatically. All duty updates are committed only at PWM period boundaries, so the LED output never glitches mid-period. It sits between the button/rotary front end (debounce, rotation decoder) and the PWM generator/LCD status logic.

Parameters:
MAX_LEVEL, 20, top duty level in 5% units (20 = 100%)
HOLD_PERIODS, 8, PWM periods spent in HOLD_HIGH / HOLD_LOW
RATE_RESET, 3, rate value after reset (0..7)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
mode_btn  input  1  one-cycle pulse (debounced edge); toggles MANUAL/AUTO
rot_event  input  1  one-cycle pulse per encoder detent
rot_right  input  1  direction qualifier, valid with rot_event
period_end  input  1  one-cycle pulse from PWM generator on the last tick of each period
duty_level  output  5  committed duty, 0..MAX_LEVEL, 5% units
cfg_valid  output  1  one-cycle pulse in the cycle duty_level takes a new value
state_code  output  3  0 MANUAL, 1 RAMP_UP, 2 HOLD_HIGH, 3 RAMP_DOWN, 4 HOLD_LOW
rate  output  3  AUTO step rate, 0 slowest .. 7 fastest

Behaviour:
- Reset (reset==0, asynchronous): state MANUAL, duty_level 0, pending 0, rate RATE_RESET, step_cnt 0, hold_cnt 0, cfg_valid 0.
- All other updates occur on posedge clk. Outputs are registered.
- Rotary direction: rot_event with !rot_right = increment; with rot_right = decrement.
- MANUAL mode:
  - rot_event adjusts the internal pending level, saturating at 0 and MAX_LEVEL.
  - On period_end, if pending != duty_level, then duty_level <= pending and cfg_valid pulses in the same edge.
  - If rot_event and period_end occur together, the commit uses the pending value from before this edge. The rotation lands in pending and is committed at the next period_end.
- AUTO mode:
  - rot_event adjusts rate (increment/decrement), saturating at 0 and 7. duty_level is unaffected.
  - A step occurs on the period_end at which step_cnt == 7-rate. step_cnt then clears; otherwise it increments on each period_end.
  - RAMP_UP: each step does duty_level+1 with cfg_valid. When the step produces MAX_LEVEL, go to HOLD_HIGH with hold_cnt 0.
  - HOLD_HIGH: hold_cnt increments per period_end. On the period_end where hold_cnt == HOLD_PERIODS-1, go to RAMP_DOWN with step_cnt 0.
  - RAMP_DOWN: each step does duty_level-1 with cfg_valid. On reaching 0, go to HOLD_LOW.
  - HOLD_LOW: mirrors HOLD_HIGH, then goes to RAMP_UP with step_cnt 0.
- Mode toggle (mode_btn):
  - MANUAL -> AUTO: go to RAMP_DOWN if duty_level==MAX_LEVEL, else RAMP_UP. step_cnt and hold_cnt clear.
  - AUTO -> MANUAL: pending <= duty_level. rate is retained.
  - duty_level never changes on the toggle edge.
  - mode_btn coincident with period_end: the toggle wins, and no commit/step happens that edge.
- cfg_valid is high for exactly one cycle per duty_level change and never when the value is unchanged.
- Reset asserted mid-ramp returns immediately to the reset values, with no cfg_valid pulse.

Test Plan:
- Reset: hold reset=0, apply rot_event/period_end -> duty_level 0, state_code 0, rate 3, cfg_valid 0. Release reset -> outputs unchanged.
- MANUAL: 3 increment detents, then period_end -> duty_level 3 with a single cfg_valid pulse. 25 more increments + period_end -> 20 (saturation). A second period_end with no rotation -> no cfg_valid.
- Coincidence: rot_event(increment) on the same edge as period_end with pending=5, duty=4 -> duty_level 5. The next period_end -> 6.
- AUTO, rate 7: toggle from duty 0 and pulse period_end continuously -> duty rises 1 per period to 20, holds 20 for 8 periods (state 2), falls 1 per period to 0, holds 8 periods, then state 1.
- AUTO, rate 0: each step takes 8 period_ends. Decrement rot_event at rate 0 keeps rate 0. Toggle at duty 20 -> state 3.
- mode_btn coincident with period_end mid-ramp at duty 9 -> state 0, duty_level stays 9, no cfg_valid. Async reset mid-ramp -> duty 0 immediately, without waiting for clk.
